// File: rtl/fifo_pkg.sv
// fifo_pkg: read-mode constants and helpers shared by the FIFO blocks.
package fifo_pkg;
   localparam int FIFO_MODE_REG  = 0;
   localparam int FIFO_MODE_FWFT = 1;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage, synchronous write, combinational or registered read.
module fifo_ram #(
   parameter int N      = 8,
   parameter int N_ADDR = 4,
   parameter bit REG_RD = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic [N_ADDR-1:0] i_waddr,
   input  logic [N-1:0]      i_wdata,
   input  logic              i_re,
   input  logic [N_ADDR-1:0] i_raddr,
   output logic [N-1:0]      o_rdata
);
   logic [N-1:0] mem_q [2**N_ADDR];
   always_ff @(posedge i_clk)
      if (i_we) mem_q[i_waddr] <= i_wdata;
   if (REG_RD) begin : g_reg
      logic [N-1:0] rdata_q;
      always_ff @(posedge i_clk or negedge i_rst_n)
         if (!i_rst_n) rdata_q <= '0;
         else if (i_re) rdata_q <= mem_q[i_raddr];
      assign o_rdata = rdata_q;
   end else begin : g_comb
      // Reset and read enable only matter for the registered port.
      logic unused_ok;
      assign unused_ok = i_rst_n ^ i_re;
      assign o_rdata   = mem_q[i_raddr];
   end
endmodule

// File: rtl/fifo_ctl.sv
// fifo_ctl: parametrised synchronous FIFO with occupancy, almost flags, sticky errors,
// flush, and first-word-fall-through or registered read.
module fifo_ctl import fifo_pkg::*; #(
   parameter int N        = 8,
   parameter int N_ADDR   = 4,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = 1
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_clr,
   input  logic            i_wr,
   input  logic [N-1:0]    i_data,
   output logic            o_full,
   output logic            o_afull,
   input  logic            i_rd,
   output logic [N-1:0]    o_data,
   output logic            o_valid,
   output logic            o_empty,
   output logic            o_aempty,
   output logic [N_ADDR:0] o_count,
   output logic            o_ovf,
   output logic            o_udf
);
   localparam logic [N_ADDR:0] FULL_CNT = (N_ADDR+1)'(2**N_ADDR);
   localparam logic [N_ADDR:0] AF_CNT   = (N_ADDR+1)'(AF_LEVEL);
   localparam logic [N_ADDR:0] AE_CNT   = (N_ADDR+1)'(AE_LEVEL);
   logic [N_ADDR:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic            ovf_q, ovf_d, udf_q, udf_d, valid_q, valid_d;
   logic            rd, wr, rd_en, wr_en;
   assign o_count  = wr_ptr_q - rd_ptr_q;
   assign o_full   = o_count == FULL_CNT;
   assign o_empty  = o_count == '0;
   assign o_afull  = o_count >= AF_CNT;
   assign o_aempty = o_count <= AE_CNT;
   assign o_ovf    = ovf_q;
   assign o_udf    = udf_q;
   assign o_valid  = (FWFT == FIFO_MODE_FWFT) ? !o_empty : valid_q;
   // A full FIFO still accepts a write when the head is popped in the same cycle.
   always_comb begin
      rd       = i_rd && !o_empty;
      wr       = i_wr && (!o_full || rd);
      rd_en    = rd && !i_clr;
      wr_en    = wr && !i_clr;
      wr_ptr_d = i_clr ? '0 : (wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q);
      rd_ptr_d = i_clr ? '0 : (rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q);
      ovf_d    = !i_clr && (ovf_q || (i_wr && o_full && !rd));
      udf_d    = !i_clr && (udf_q || (i_rd && o_empty));
      valid_d  = rd_en;
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         valid_q  <= valid_d;
      end
   fifo_ram #(
      .N      (N),
      .N_ADDR (N_ADDR),
      .REG_RD (FWFT != FIFO_MODE_FWFT)
   ) u_ram (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_we    (wr_en),
      .i_waddr (wr_ptr_q[N_ADDR-1:0]),
      .i_wdata (i_data),
      .i_re    (rd_en),
      .i_raddr (rd_ptr_q[N_ADDR-1:0]),
      .o_rdata (o_data)
   );
endmodule

// File: tb/tb_fifo_ctl.sv
// tb_fifo_ctl: drives FWFT and registered-read FIFOs with identical stimulus against a queue model.
module tb_fifo_ctl;
   logic       clk = 1'b0, rst_n = 1'b0, clr = 1'b0, wr = 1'b0, rd = 1'b0;
   logic [7:0] din = '0;
   logic       f_full, f_afull, f_empty, f_aempty, f_valid, f_ovf, f_udf;
   logic       r_full, r_afull, r_empty, r_aempty, r_valid, r_ovf, r_udf;
   logic [7:0] f_data, r_data;
   logic [4:0] f_count, r_count;
   always #5 clk = ~clk;
   fifo_ctl #(.FWFT(1)) u_fwft (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_wr(wr), .i_data(din),
      .o_full(f_full), .o_afull(f_afull), .i_rd(rd), .o_data(f_data), .o_valid(f_valid),
      .o_empty(f_empty), .o_aempty(f_aempty), .o_count(f_count), .o_ovf(f_ovf), .o_udf(f_udf)
   );
   fifo_ctl #(.FWFT(0)) u_reg (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_wr(wr), .i_data(din),
      .o_full(r_full), .o_afull(r_afull), .i_rd(rd), .o_data(r_data), .o_valid(r_valid),
      .o_empty(r_empty), .o_aempty(r_aempty), .o_count(r_count), .o_ovf(r_ovf), .o_udf(r_udf)
   );
   typedef struct {
      logic       w, r, c;
      logic [7:0] d;
      int         cnt;
      logic       ovf;
   } vec_t;
   vec_t       tbl [18];
   int         checks = 0, failures = 0;
   logic [7:0] mq [$];
   logic [7:0] eq [$];
   logic       m_ovf = 1'b0, m_udf = 1'b0, m_val = 1'b0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic model_reset();
      mq.delete();
      eq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_val = 1'b0;
   endtask
   task automatic check_all();
      int c;
      c = mq.size();
      chk("f_count", 32'(f_count), c);
      chk("r_count", 32'(r_count), c);
      chk("f_full", f_full, c == 16);
      chk("r_full", r_full, c == 16);
      chk("f_afull", f_afull, c >= 12);
      chk("r_afull", r_afull, c >= 12);
      chk("f_empty", f_empty, c == 0);
      chk("r_empty", r_empty, c == 0);
      chk("f_aempty", f_aempty, c <= 2);
      chk("r_aempty", r_aempty, c <= 2);
      chk("f_ovf", f_ovf, m_ovf);
      chk("r_ovf", r_ovf, m_ovf);
      chk("f_udf", f_udf, m_udf);
      chk("r_udf", r_udf, m_udf);
      chk("f_valid", f_valid, c != 0);
      if (c != 0) chk("f_data", f_data, mq[0]);
      chk("r_valid", r_valid, m_val);
      if (r_valid) begin
         if (eq.size() == 0) chk("r_unexpected_word", r_data, 32'hFFFF_FFFF);
         else chk("r_data", r_data, eq.pop_front());
      end
   endtask
   task automatic cycle(input logic w, input logic r, input logic c, input logic [7:0] d);
      logic full, empty, pr, pw;
      wr = w; rd = r; clr = c; din = d;
      full  = mq.size() == 16;
      empty = mq.size() == 0;
      if (c) begin
         mq.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         m_val = 1'b0;
      end else begin
         pr = r && !empty;
         pw = w && (!full || pr);
         if (w && full && !pr) m_ovf = 1'b1;
         if (r && empty) m_udf = 1'b1;
         m_val = pr;
         if (pr) eq.push_back(mq.pop_front());
         if (pw) mq.push_back(d);
      end
      @(posedge clk);
      #1;
      check_all();
   endtask
   initial begin
      for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 8'(i), i + 1, 1'b0};
      tbl[16] = '{1'b1, 1'b0, 1'b0, 8'hAA, 16, 1'b1};
      tbl[17] = '{1'b1, 1'b1, 1'b0, 8'h55, 16, 1'b1};
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      chk("reset_r_data", r_data, 8'h00);
      rst_n = 1'b1;
      for (int i = 0; i < 18; i++) begin
         cycle(tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].d);
         chk("tbl_count", 32'(f_count), tbl[i].cnt);
         chk("tbl_ovf", f_ovf, tbl[i].ovf);
      end
      for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
      chk("last_word_55", r_data, 8'h55);
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      chk("udf_set", f_udf, 1'b1);
      chk("udf_no_valid", r_valid, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      chk("clr_udf", r_udf, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 8'h99);
      chk("clr_wr_count", 32'(r_count), 0);
      cycle(1'b1, 1'b0, 1'b0, 8'h3C);
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      chk("reg_valid", r_valid, 1'b1);
      chk("reg_data_3c", r_data, 8'h3C);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      chk("reg_valid_pulse", r_valid, 1'b0);
      chk("reg_data_hold", r_data, 8'h3C);
      cycle(1'b1, 1'b0, 1'b0, 8'h11);
      cycle(1'b1, 1'b0, 1'b0, 8'h22);
      cycle(1'b1, 1'b0, 1'b0, 8'h33);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
         cycle(1'b0, 1'b1, 1'b0, 8'h00);
      end
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
      chk("pre_reset_count", 32'(f_count), 5);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("async_r_data", r_data, 8'h00);
      wr = 1'b0; rd = 1'b0; clr = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle(1'b1, 1'b0, 1'b0, 8'h77);
      chk("head_after_reset", f_data, 8'h77);
      chk("sb_drained", eq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fifo_ctl.md
Name: fifo_ctl

Overview:
Parametrised synchronous FIFO and successor to the basic UART FIFO.
- Adds an asynchronous active-low reset, an occupancy count, and programmable almost-full/almost-empty flags.
- Adds sticky overflow/underflow error flags, a synchronous flush, and a selectable read mode: first-word-fall-through or registered read.
- Sits between UART rx/tx engines and their consumers/producers, and anywhere else the design needs buffering.

Parameters:
- N, 8: data bus bit width.
- N_ADDR, 4: address bit width; depth = 2**N_ADDR entries.
- AF_LEVEL, 12: o_afull asserts when count >= AF_LEVEL; legal range 1..2**N_ADDR.
- AE_LEVEL, 2: o_aempty asserts when count <= AE_LEVEL; legal range 0..2**N_ADDR-1.
- FWFT, 1: 1 = head word visible combinationally on o_data; 0 = registered read, data appears one cycle after the pop.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_clr  input  1  synchronous flush: empties FIFO and clears error flags.
- i_wr  input  1  write request.
- i_data  input  N  write data.
- o_full  output  1  count == 2**N_ADDR.
- o_afull  output  1  almost-full.
- i_rd  input  1  read (pop) request.
- o_data  output  N  read data.
- o_valid  output  1  FWFT=1: equals !o_empty. FWFT=0: one-cycle pulse, o_data valid.
- o_empty  output  1  count == 0.
- o_aempty  output  1  almost-empty.
- o_count  output  N_ADDR+1  current occupancy, 0..2**N_ADDR.
- o_ovf  output  1  sticky: write attempted while full and rejected.
- o_udf  output  1  sticky: read attempted while empty.

Behaviour:
- Reset: asynchronous on i_rst_n low; release is synchronous to i_clk.
  - Clears wr/rd pointers (N_ADDR+1 bits each), o_ovf, o_udf, o_valid, and the o_data register (FWFT=0) to 0.
  - After reset: o_empty=1, o_aempty=1, o_full=0, o_afull=0 (AF_LEVEL>=1), o_count=0.
  - Storage array is not reset.
  - Reset mid-operation discards all contents; the first write after release is the head.
- Accept rules, evaluated on each cycle's registered state:
  - rd = i_rd && !o_empty.
  - wr = i_wr && (!o_full || rd). A write is accepted when full if a pop occurs in the same cycle.
  - Simultaneous wr and rd: count unchanged, both pointers advance.
  - Empty with both requested: write accepted, read rejected (o_udf sets).
- Pointers increment by 1 and wrap naturally modulo 2**(N_ADDR+1). Storage address = low N_ADDR bits.
- o_count = wr_ptr - rd_ptr, modulo 2**(N_ADDR+1).
- Flags o_full, o_empty, o_afull, o_aempty are combinational from the registered pointers; they update the cycle after the causing edge, no further latency.
- Error flags:
  - o_ovf sets on i_wr && o_full && !rd.
  - o_udf sets on i_rd && o_empty.
  - Both hold until i_clr or reset.
- i_clr, synchronous, highest priority over wr/rd in the same cycle:
  - Sets both pointers to 0 and clears o_ovf/o_udf.
  - Any same-cycle write or read is ignored and does not set error flags.
  - FWFT=0: o_valid=0 next cycle.
- FWFT=1 read: o_data = mem[rd_ptr] combinationally, meaningful only when !o_empty.
  - Write-to-visible latency is 1 cycle: the word written at edge k is on o_data after edge k.
- FWFT=0 read: on an accepted rd, the o_data register loads mem[rd_ptr] and o_valid=1 for exactly one cycle.
  - o_data holds its last value otherwise.
  - A rejected read leaves o_valid=0.
- Latency summary: write-to-pop-available is 1 cycle; in FWFT=0, pop-to-data is 1 cycle.
- Throughput: one write and one read per cycle sustained.

Decomposition:
- Shared package fifo_pkg holds:
  - function clog2;
  - the read-mode constants FIFO_MODE_REG=0 and FIFO_MODE_FWFT=1.
- Pointer, count and flag logic stays in fifo_ctl.
- One sub-module, fifo_ram (N, N_ADDR): simple dual-port storage.
  - Synchronous write port.
  - Combinational or registered read port, selected by a parameter.
  - Isolated so iCE40 BRAM/LUT-RAM inference is controlled in one place.

Test Plan:
- Reset then fill (N=8, N_ADDR=4): write 0x00..0x0F.
  - o_count steps 0..16; o_afull rises when count reaches 12; o_full=1 at 16; o_aempty=0 once count reaches 3.
- Full with i_wr=1, i_rd=0 writing 0xAA -> o_ovf=1, count stays 16, head still 0x00.
- Full with i_wr=1, i_rd=1 writing 0x55 -> pop 0x00, count stays 16, 0x55 read out as the 16th word later.
- Empty with i_rd=1 -> o_udf=1, o_valid=0, pointers unchanged.
  - Then assert i_clr -> o_udf=0.
  - Assert i_clr together with i_wr -> count stays 0.
- FWFT=0: write 0x3C, then pulse i_rd -> o_valid=1 for one cycle with o_data=0x3C next cycle. Back-to-back reads give one word per cycle.
- Wrap: 40 interleaved write/read pairs with incrementing data -> output sequence exact.
  - Then assert i_rst_n low while count=5 -> flags return immediately (asynchronously) to reset values, o_count=0.
